// File: rtl/fifo_drain_unit_if.sv
// Interfaces for the drain unit: the read side of the 16x32 synchronous FIFO
// and the valid/ready word stream presented to the next stage.

interface drain_fifo_if #(
  parameter int DATA_W = 32
);
  logic              fifo_rd_en;
  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_data;

  // Drain unit side: issues read strobes, receives status and data.
  modport master (output fifo_rd_en, input fifo_empty, input fifo_data);
  // FIFO side: receives read strobes, supplies status and data.
  modport slave  (input fifo_rd_en, output fifo_empty, output fifo_data);
endinterface

interface drain_stream_if #(
  parameter int DATA_W = 32
);
  logic              m_valid;
  logic [DATA_W-1:0] m_data;
  logic              m_ready;

  // Producer of the word stream.
  modport master (output m_valid, output m_data, input m_ready);
  // Consumer of the word stream.
  modport slave  (input m_valid, input m_data, output m_ready);
endinterface

// File: rtl/fifo_drain_unit.sv
// Drains a synchronous FIFO with one-cycle read latency into a small circular
// skid queue and presents the words on a valid/ready stream. Reads are issued
// only against free queue credit, so the in-flight word always has a slot.

module fifo_drain_unit #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,   // power of two, >= 3 for full throughput
  parameter int CNT_W  = 16
) (
  input  logic               clk,
  input  logic               reset,     // asynchronous, active low
  input  logic               drain_en,
  drain_fifo_if.master       fifo,
  drain_stream_if.master     strm,
  output logic [CNT_W-1:0]   word_cnt,
  output logic               busy
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_FLUSH  = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [OCC_W-1:0]  r_occ;
  logic              r_pending;
  logic [PTR_W-1:0]  r_head;
  logic [PTR_W-1:0]  r_tail;
  logic [DATA_W-1:0] r_queue [DEPTH];
  logic [CNT_W-1:0]  r_word_cnt;

  logic [OCC_W:0]    w_inflight;
  logic              w_credit;
  logic              w_work;
  logic              w_rd_en;
  logic              w_valid;
  logic              w_capture;
  logic              w_pop;

  // Words already queued plus the one still coming back from the FIFO.
  assign w_inflight = {1'b0, r_occ} + {{OCC_W{1'b0}}, r_pending};
  assign w_credit   = (w_inflight < (OCC_W + 1)'(DEPTH));
  assign w_work     = r_pending | (r_occ != '0);

  // Read strobe depends only on registers, the FIFO status and drain_en;
  // m_ready deliberately stays out of this path. Reset forces it low.
  assign w_rd_en = reset & drain_en & ~fifo.fifo_empty & w_credit &
                   (r_state != S_FLUSH);
  assign fifo.fifo_rd_en = w_rd_en;

  assign w_valid   = (r_occ != '0);
  assign w_capture = r_pending;
  assign w_pop     = w_valid & strm.m_ready;

  assign strm.m_valid = w_valid;
  assign strm.m_data  = w_valid ? r_queue[r_head] : '0;
  assign word_cnt     = r_word_cnt;
  assign busy         = (r_state != S_IDLE);

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  // Next-state logic: FLUSH lets outstanding words drain with reads stopped.
  always_comb begin
    // NOTE: default assigned first so no path leaves w_state_next unassigned
    // (which would infer a latch).
    w_state_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (drain_en) w_state_next = S_ACTIVE;
      end
      S_ACTIVE: begin
        if (!drain_en) w_state_next = w_work ? S_FLUSH : S_IDLE;
      end
      S_FLUSH: begin
        if (drain_en)     w_state_next = S_ACTIVE;
        else if (!w_work) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Read-latency tracking, queue pointers, occupancy and delivered count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pending  <= 1'b0;
      r_occ      <= '0;
      r_head     <= '0;
      r_tail     <= '0;
      r_word_cnt <= '0;
    end else begin
      r_pending <= w_rd_en;
      if (w_capture) r_tail <= r_tail + 1'b1;
      if (w_pop) begin
        r_head     <= r_head + 1'b1;
        r_word_cnt <= r_word_cnt + 1'b1;
      end
      r_occ <= r_occ + {{(OCC_W-1){1'b0}}, w_capture}
                     - {{(OCC_W-1){1'b0}}, w_pop};
    end
  end

  // Skid queue storage: written with the FIFO word one cycle after the read.
  always_ff @(posedge clk) begin
    // NOTE: storage is not reset; an entry is only visible once r_occ counts
    // it, and m_data is forced to zero while the queue is empty.
    if (w_capture) r_queue[r_tail] <= fifo.fifo_data;
  end

endmodule
